// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches words over a req/ack handshake, holds each one for the
// decoder, and computes the next PC from the decoder's jump/branch outputs and the ALU zero flag.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             jump,
    input  logic             j_and_link,
    input  logic             j_reg,
    input  logic             branch_eq,
    input  logic             branch_not_eq,
    input  logic             zero,
    input  logic [31:0]      rs_data,
    output logic [31:0]      pc,
    output logic [31:0]      link_addr,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        jr_sel;
    logic        jump_any;
    logic        taken;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    // j_reg comes from funct alone, so it only means jr when the opcode is R-type.
    assign jr_sel   = j_reg & (instr_q[31:26] == 6'b0);
    assign jump_any = jump | j_and_link;
    assign taken    = (branch_eq & zero) | (branch_not_eq & ~zero);

    always_comb begin
        next_pc = pc_plus4;
        if (jr_sel) begin
            next_pc = rs_data;
        end else if (jump_any) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        req_d     = req_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                req_d   = 1'b1;
            end
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StIssue;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            StIssue: begin
                if (instr_ready) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = StFetch;
                    req_d     = 1'b1;
                    valid_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign link_addr   = pc_plus4;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a memory responder with programmable wait states and a
// scoreboard queue of expected PCs pushed at each issue and popped once the PC updates.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump, j_and_link, j_reg, branch_eq, branch_not_eq, zero;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;
    int exp_retired = 0;
    logic [31:0] exp_pc_q[$];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .jump          (jump),
        .j_and_link    (j_and_link),
        .j_reg         (j_reg),
        .branch_eq     (branch_eq),
        .branch_not_eq (branch_not_eq),
        .zero          (zero),
        .rs_data       (rs_data),
        .pc            (pc),
        .link_addr     (link_addr),
        .retired       (retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        jump = 0; j_and_link = 0; j_reg = 0; branch_eq = 0; branch_not_eq = 0; zero = 0;
        rs_data = 32'hDEAD_BEEF;
    endtask

    // Waits for a request at addr, holds ack off for `waits` cycles, then returns word.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            instr_ready = 1'b1;  // must be ignored while fetching
            @(negedge clk);
            chk("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, addr);
            chk("wait_valid", instr_valid, 1'b0);
        end
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        chk("issue_valid", instr_valid, 1'b1);
        chk("issue_req", imem_req, 1'b0);
        chk("issue_instr", instr, word);
        chk("issue_pc", pc, addr);
    endtask

    task automatic do_issue(input logic [31:0] exp_next);
        logic [31:0] e;
        chk("link_addr", link_addr, pc + 32'd4);
        exp_pc_q.push_back(exp_next);
        exp_retired++;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        clear_ctl();
        e = exp_pc_q.pop_front();
        chk("next_pc", pc, e);
        chk("retired", retired, exp_retired);
        chk("refetch_req", imem_req, 1'b1);
        chk("refetch_valid", instr_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        clear_ctl();
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_retired", retired, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", imem_req, 1'b1);

        // addi, zero-wait
        do_fetch(32'h0, 32'h2008_0005, 0);
        do_issue(32'h4);
        // jr to 0x10 with 3 wait states, plus a stray ack during ISSUE
        do_fetch(32'h4, 32'h0000_0008, 3);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stray_ack_instr", instr, 32'h0000_0008);
        chk("stray_ack_valid", instr_valid, 1'b1);
        j_reg = 1; rs_data = 32'h10;
        do_issue(32'h10);
        // beq taken backward
        do_fetch(32'h10, 32'h1000_FFFC, 0);
        branch_eq = 1; zero = 1;
        do_issue(32'h4);
        do_fetch(32'h4, 32'h0000_0008, 1);
        j_reg = 1; rs_data = 32'h10;
        do_issue(32'h10);
        // beq not taken
        do_fetch(32'h10, 32'h1000_FFFC, 0);
        branch_eq = 1; zero = 0;
        do_issue(32'h14);
        do_fetch(32'h14, 32'h0000_0008, 0);
        j_reg = 1; rs_data = 32'h10;
        do_issue(32'h10);
        // bne taken
        do_fetch(32'h10, 32'h1400_FFFC, 0);
        branch_not_eq = 1; zero = 0;
        do_issue(32'h4);
        // both branch flags: taken regardless of zero
        do_fetch(32'h4, 32'h1000_0010, 0);
        branch_eq = 1; branch_not_eq = 1; zero = 0;
        do_issue(32'h48);
        do_fetch(32'h48, 32'h0000_0008, 0);
        j_reg = 1; rs_data = 32'h4000_0008;
        do_issue(32'h4000_0008);
        // jal
        do_fetch(32'h4000_0008, 32'h0C00_0100, 0);
        chk("jal_link", link_addr, 32'h4000_000C);
        jump = 1; j_and_link = 1;
        do_issue(32'h4000_0400);
        // j_reg with non-zero opcode is blocked
        do_fetch(32'h4000_0400, 32'h2000_0008, 0);
        j_reg = 1; rs_data = 32'h100;
        do_issue(32'h4000_0404);
        // jr outranks jump
        do_fetch(32'h4000_0404, 32'h0000_0008, 0);
        j_reg = 1; jump = 1; rs_data = 32'h100;
        do_issue(32'h100);

        // Reset in the middle of a pending fetch
        @(negedge clk);
        chk("pend_req", imem_req, 1'b1);
        chk("pend_addr", imem_addr, 32'h100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", imem_req, 1'b0);
        chk("async_pc", pc, 32'h0);
        chk("async_retired", retired, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hFEED_FACE;
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = 0;
        @(negedge clk);
        chk("late_ack_valid", instr_valid, 1'b0);
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_req", imem_req, 1'b1);
        imem_ack = 1'b0;
        do_fetch(32'h0, 32'h2008_0005, 1);
        do_issue(32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-side counterpart of the opcode/funct control decoder.
- Fetches instruction words from instruction memory over a req/ack handshake and presents each word to the decoder/datapath.
- Consumes the decoder's jump, j_and_link, j_reg, branch_eq and branch_not_eq outputs plus the ALU zero flag to compute the next PC.
- Sits between instruction memory and the decode stage; supplies the PC-relative link address for jal.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  held instruction to decoder (opcode = instr[31:26], funct = instr[5:0]).
- instr_valid  out  1  instr is valid and awaiting execution.
- instr_ready  in  1  datapath has completed the instruction this cycle; control inputs and zero are valid.
- jump, j_and_link, j_reg, branch_eq, branch_not_eq  in  1 each  decoder outputs for the current instr.
- zero  in  1  ALU zero flag.
- rs_data  in  32  register rs value, jr target.
- pc  out  32  address of the current instruction.
- link_addr  out  32  pc+4, written to $31 by jal.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, retired=0. Outputs change immediately on assertion, not at the next edge.
- Reset mid-fetch abandons the request. Any ack arriving during or after reset is ignored until the next FETCH.
- States: IDLE, FETCH, ISSUE.
  - IDLE -> FETCH on the first rising edge after rst_n deasserts.
  - FETCH: imem_req=1, imem_addr=pc held stable. On an edge with imem_ack=1: instr<=imem_rdata, go to ISSUE. A same-cycle ack is accepted.
  - ISSUE: instr_valid=1, imem_req=0. An imem_ack here is ignored. On an edge with instr_ready=1: pc<=next_pc, retired<=retired+1 (wraps modulo 2^CNT_W), go to FETCH.
- Latency: minimum 2 cycles per instruction with zero-wait memory (1 FETCH, 1 ISSUE). Each memory wait cycle adds 1.
- pc_plus4 = pc + 32'd4, 32-bit wraparound; link_addr = pc_plus4 (no delay slot).
- next_pc priority, highest first:
  1. jr_q = j_reg & (instr[31:26]==6'b0): next_pc = rs_data. j_reg is qualified here because the decoder derives it from funct alone.
  2. jump (j or jal): next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. taken = (branch_eq & zero) | (branch_not_eq & ~zero): next_pc = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  4. Otherwise: next_pc = pc_plus4.
- Branch target arithmetic is 32-bit two's complement with wraparound. No misalignment trap; rs_data[1:0] is used as given.
- If branch_eq and branch_not_eq are both asserted, taken = 1 regardless of zero.
- Control inputs and zero are sampled only on the ISSUE edge with instr_ready=1; ignored otherwise.
- instr_ready in FETCH or IDLE has no effect.
- pc and instr are stable throughout ISSUE. link_addr is valid whenever instr_valid=1.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory returning 32'h2008_0005 (addi) -> imem_addr=0 in the cycle after IDLE; instr_valid the next cycle; after instr_ready, pc=4, retired=1.
- Memory ack delayed 3 cycles -> imem_req stays high and imem_addr stays 0 for 3 cycles; instr_valid only after the ack edge; extra acks in ISSUE ignored.
- pc=0x0000_0010, instr beq with imm=16'hFFFC, branch_eq=1, zero=1 -> next pc=0x0000_0004. Same with zero=0 -> pc=0x0000_0014. bne with zero=0 -> pc=0x0000_0004.
- pc=0x4000_0008, jal with instr[25:0]=26'h0000_100 -> link_addr=0x4000_000C, next pc=0x4000_0400.
- jr: opcode=0, funct=6'h08, j_reg=1, rs_data=0x0000_0100 -> pc=0x100. Opcode=6'h08 with funct bits 6'h08 and j_reg=1 -> pc=pc+4 (qualifier blocks it).
- rst_n pulled low during FETCH with memory pending -> imem_req drops asynchronously; pc=RESET_PC; a late ack after release is not captured until FETCH re-enters.
